qdeconv2d_seq: RTL

QDECONV2D_SEQ -- requirements
Module: qdeconv2d_seq

---
 rtl/qconv_pkg.sv | 44 ++++
 rtl/qdeconv2d_seq_if.sv | 49 ++++
 rtl/qdeconv_tap_addr.sv | 43 ++++
 rtl/qdeconv2d_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/qconv_pkg.sv
// Shared types and helpers for the quantised transposed-convolution block.
//   state_t  : sequencer states (IDLE / RUN / OUT)
//   tap_t    : result of mapping an (output pixel, kernel tap) pair onto the
//              input feature map: validity plus input row/column
//   cw()     : counter width for a range of n values (never below 1 bit)
//   tap_map(): the transposed-convolution index rule in plain arithmetic
package qconv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam int IDX_W = 16;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] ih;
    logic [IDX_W-1:0] iw;
  } tap_t;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // An output pixel (oh, ow) receives input (ih, iw) through tap (kh, kw)
  // when oh + pt - kh lands exactly on a stride multiple inside the input.
  function automatic tap_t tap_map(input int oh, input int ow, input int kh, input int kw,
                                   input int pt, input int pl, input int sh, input int sw,
                                   input int xh, input int xw);
    int   th;
    int   tw;
    tap_t r;
    th      = oh + pt - kh;
    tw      = ow + pl - kw;
    r.valid = (th >= 0) && (tw >= 0) && (th % sh == 0) && (tw % sw == 0) &&
              (th / sh < xh) && (tw / sw < xw);
    r.ih    = IDX_W'(th / sh);
    r.iw    = IDX_W'(tw / sw);
    return r;
  endfunction

endpackage

// File: rtl/qdeconv2d_seq_if.sv
// Job/pixel bus of qdeconv2d_seq.
//   slave  : the accelerator (takes a job, produces pixels)
//   master : the environment (offers jobs, consumes pixels)
// Job side   : s_valid/s_ready handshake with feature map x, kernel k, bias b.
// Pixel side : m_valid/m_ready handshake with all-channel pixel m_y, its
//              coordinates m_h/m_w and m_last on the final pixel.
interface qdeconv2d_seq_if
  import qconv_pkg::*;
#(
  parameter int XH = 4,
  parameter int XW = 4,
  parameter int XC = 1,
  parameter int KH = 3,
  parameter int KW = 3,
  parameter int SH = 2,
  parameter int SW = 2,
  parameter int YC = 8,
  parameter int XB = 11,
  parameter int KB = 6
);
  localparam int YH = XH * SH;
  localparam int YW = XW * SW;
  localparam int YB = XB + KB + $clog2(KH * KW * XC + 1);
  localparam int HW = cw(YH);
  localparam int WW = cw(YW);

  logic                                        s_valid;
  logic                                        s_ready;
  logic [XH-1:0][XW-1:0][XC-1:0][XB-1:0]       x;
  logic [KH-1:0][KW-1:0][XC-1:0][YC-1:0][KB-1:0] k;
  logic [YC-1:0][KB-1:0]                       b;
  logic                                        m_valid;
  logic                                        m_ready;
  logic [YC-1:0][YB-1:0]                       m_y;
  logic [HW-1:0]                               m_h;
  logic [WW-1:0]                               m_w;
  logic                                        m_last;

  modport slave (
    input  s_valid, x, k, b, m_ready,
    output s_ready, m_valid, m_y, m_h, m_w, m_last
  );

  modport master (
    output s_valid, x, k, b, m_ready,
    input  s_ready, m_valid, m_y, m_h, m_w, m_last
  );

endinterface

// File: rtl/qdeconv_tap_addr.sv
// Combinational tap address generator.
//   oh_i, ow_i : output pixel coordinates
//   kh_i, kw_i : kernel tap coordinates
//   ih_o, iw_o : input pixel feeding this tap (meaningful only when valid_o)
//   valid_o    : the tap lands on a real input pixel
module qdeconv_tap_addr
  import qconv_pkg::*;
#(
  parameter int XH  = 4,
  parameter int XW  = 4,
  parameter int KH  = 3,
  parameter int KW  = 3,
  parameter int SH  = 2,
  parameter int SW  = 2,
  parameter int OHW = cw(XH * SH),
  parameter int OWW = cw(XW * SW),
  parameter int KHW = cw(KH),
  parameter int KWW = cw(KW),
  parameter int IHW = cw(XH),
  parameter int IWW = cw(XW)
) (
  input  logic [OHW-1:0] oh_i,
  input  logic [OWW-1:0] ow_i,
  input  logic [KHW-1:0] kh_i,
  input  logic [KWW-1:0] kw_i,
  output logic [IHW-1:0] ih_o,
  output logic [IWW-1:0] iw_o,
  output logic           valid_o
);
  localparam int PT = (KH - SH) / 2;
  localparam int PL = (KW - SW) / 2;

  tap_t t;

  always_comb begin
    t       = tap_map(int'(oh_i), int'(ow_i), int'(kh_i), int'(kw_i),
                      PT, PL, SH, SW, XH, XW);
    valid_o = t.valid;
    ih_o    = IHW'(t.ih);
    iw_o    = IWW'(t.iw);
  end

endmodule

// File: rtl/qdeconv2d_seq.sv
// Sequential quantised 2-D transposed convolution.
//   clk  : sole clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : qdeconv2d_seq_if slave (job in: s_valid/s_ready, x, k, b;
//          pixels out: m_valid/m_ready, m_y, m_h, m_w, m_last)
// One job produces YH*YW pixels in raster order. Each pixel takes KH*KW*XC
// RUN cycles (one tap per cycle, xc innermost, then kw, then kh) plus one
// OUT cycle while m_ready is high. All YC channels accumulate in parallel.
module qdeconv2d_seq
  import qconv_pkg::*;
#(
  parameter int XH = 4,
  parameter int XW = 4,
  parameter int XC = 1,
  parameter int KH = 3,
  parameter int KW = 3,
  parameter int SH = 2,
  parameter int SW = 2,
  parameter int YC = 8,
  parameter int XB = 11,
  parameter int KB = 6
) (
  input logic              clk,
  input logic              rstn,
  qdeconv2d_seq_if.slave   bus
);
  localparam int YH  = XH * SH;
  localparam int YW  = XW * SW;
  localparam int MB  = XB + KB;
  localparam int YB  = MB + $clog2(KH * KW * XC + 1);
  localparam int OHW = cw(YH);
  localparam int OWW = cw(YW);
  localparam int KHW = cw(KH);
  localparam int KWW = cw(KW);
  localparam int XCW = cw(XC);
  localparam int IHW = cw(XH);
  localparam int IWW = cw(XW);

  localparam logic [OHW-1:0] OH_MAX = OHW'(YH - 1);
  localparam logic [OWW-1:0] OW_MAX = OWW'(YW - 1);
  localparam logic [KHW-1:0] KH_MAX = KHW'(KH - 1);
  localparam logic [KWW-1:0] KW_MAX = KWW'(KW - 1);
  localparam logic [XCW-1:0] XC_MAX = XCW'(XC - 1);

  state_t         state_q, state_d;
  logic [OHW-1:0] oh_q, oh_d;
  logic [OWW-1:0] ow_q, ow_d;
  logic [KHW-1:0] kh_q, kh_d;
  logic [KWW-1:0] kw_q, kw_d;
  logic [XCW-1:0] xc_q, xc_d;

  logic [XH-1:0][XW-1:0][XC-1:0][XB-1:0]         x_q;
  logic [KH-1:0][KW-1:0][XC-1:0][YC-1:0][KB-1:0] k_q;
  logic [YC-1:0][KB-1:0]                         b_q;

  logic           capture;    // job accepted this cycle
  logic           load_bias;  // entering RUN: accumulators restart from bias
  logic           add_tap;    // RUN: accumulate the current tap
  logic           last_pix;
  logic [IHW-1:0] ih;
  logic [IWW-1:0] iw;
  logic           tap_valid;

  assign last_pix = (oh_q == OH_MAX) && (ow_q == OW_MAX);

  // ---------------------------------------------------------------- FSM
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    oh_d      = oh_q;
    ow_d      = ow_q;
    kh_d      = kh_q;
    kw_d      = kw_q;
    xc_d      = xc_q;
    capture   = 1'b0;
    load_bias = 1'b0;
    add_tap   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.s_valid) begin
          capture   = 1'b1;
          load_bias = 1'b1;
          oh_d      = '0;
          ow_d      = '0;
          kh_d      = '0;
          kw_d      = '0;
          xc_d      = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        add_tap = 1'b1;
        // Taps wrap back to zero on the last one, ready for the next pixel.
        if (xc_q == XC_MAX) begin
          xc_d = '0;
          if (kw_q == KW_MAX) begin
            kw_d = '0;
            if (kh_q == KH_MAX) begin
              kh_d    = '0;
              state_d = ST_OUT;
            end else begin
              kh_d = kh_q + 1'b1;
            end
          end else begin
            kw_d = kw_q + 1'b1;
          end
        end else begin
          xc_d = xc_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (bus.m_ready) begin
          if (last_pix) begin
            oh_d    = '0;
            ow_d    = '0;
            state_d = ST_IDLE;
          end else begin
            load_bias = 1'b1;
            state_d   = ST_RUN;
            if (ow_q == OW_MAX) begin
              ow_d = '0;
              oh_d = oh_q + 1'b1;
            end else begin
              ow_d = ow_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      oh_q    <= '0;
      ow_q    <= '0;
      kh_q    <= '0;
      kw_q    <= '0;
      xc_q    <= '0;
    end else begin
      state_q <= state_d;
      oh_q    <= oh_d;
      ow_q    <= ow_d;
      kh_q    <= kh_d;
      kw_q    <= kw_d;
      xc_q    <= xc_d;
    end
  end

  // NOTE: the operand store is wide data that is always written before it is
  // read, so it carries no reset; only control state and outputs are reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      x_q <= bus.x;
      k_q <= bus.k;
      b_q <= bus.b;
    end
  end

  // ------------------------------------------------------- tap datapath
  qdeconv_tap_addr #(
    .XH (XH),
    .XW (XW),
    .KH (KH),
    .KW (KW),
    .SH (SH),
    .SW (SW),
    .OHW(OHW),
    .OWW(OWW),
    .KHW(KHW),
    .KWW(KWW),
    .IHW(IHW),
    .IWW(IWW)
  ) u_tap_addr (
    .oh_i   (oh_q),
    .ow_i   (ow_q),
    .kh_i   (kh_q),
    .kw_i   (kw_q),
    .ih_o   (ih),
    .iw_o   (iw),
    .valid_o(tap_valid)
  );

  // Zeroing the activation of an invalid tap makes every channel add zero
  // while still spending the cycle, keeping timing data-independent.
  logic signed [XB-1:0] x_sel;
  assign x_sel = tap_valid ? x_q[ih][iw][xc_q] : '0;

  wire [YC-1:0][YB-1:0] acc_y;

  for (genvar g = 0; g < YC; g++) begin : g_acc
    logic signed [KB-1:0] k_sel;
    logic signed [MB-1:0] prod;
    logic signed [YB-1:0] acc_q;

    assign k_sel    = k_q[kh_q][kw_q][xc_q][g];
    assign prod     = MB'(x_sel) * MB'(k_sel);
    assign acc_y[g] = acc_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        acc_q <= '0;
      end else if (load_bias) begin
        // On capture the operand store is not yet loaded; take bias from the bus.
        acc_q <= capture ? YB'($signed(bus.b[g])) : YB'($signed(b_q[g]));
      end else if (add_tap) begin
        acc_q <= acc_q + YB'(prod);
      end
    end
  end

  // ------------------------------------------------------------ outputs
  assign bus.s_ready = (state_q == ST_IDLE);
  assign bus.m_valid = (state_q == ST_OUT);
  assign bus.m_last  = (state_q == ST_OUT) && last_pix;
  assign bus.m_h     = oh_q;
  assign bus.m_w     = ow_q;
  assign bus.m_y     = acc_y;

endmodule
